// File: rtl/aes_inv_top.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_inv_top : iterative AES-128 inverse cipher, one round per clock.
// Optional macro AES_DEC_KEY_CACHE_EN caches the last key's rk10.  Rev 1.0
// ----------------------------------------------------------------------------
module aes_inv_top (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid,
  output logic         AES_busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] KEYX  = 2'd1;
  localparam logic [1:0] ARK   = 2'd2;
  localparam logic [1:0] ROUND = 2'd3;
  localparam logic [7:0] RCON_LAST = 8'h36;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); zero maps to zero for free
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
    return gmul(r, r);
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = ginv(a);
    return x ^ rl(x, 1) ^ rl(x, 2) ^ rl(x, 3) ^ rl(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [31:0] t);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] key_bwd(input logic [127:0] k, input logic [31:0] t);
    return {k[127:96] ^ t, k[95:64] ^ k[127:96], k[63:32] ^ k[95:64], k[31:0] ^ k[63:32]};
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic mix);
    logic [7:0]   b [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    int           src;
    for (int k = 0; k < 16; k++) begin
      src  = 4 * (((k / 4) - (k % 4) + 4) % 4) + (k % 4);
      b[k] = inv_sbox(s[127 - 8*src -: 8]) ^ rk[127 - 8*k -: 8];
    end
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
      if (mix)
        o[127 - 32*c -: 32] = {
          gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
          gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
          gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
          gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
      else
        o[127 - 32*c -: 32] = {a0, a1, a2, a3};
    end
    return o;
  endfunction

  logic [1:0]   state_q, state_d;
  logic [127:0] data_q, data_d, key_q, key_d, dout_q, dout_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         valid_q, valid_d, busy_q, busy_d;
  logic [31:0]  sub_in, ks_t;
  logic [127:0] key_next, key_prev, round_out;
`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] ckey_q, ckey_d, crk_q, crk_d;
  logic         cvld_q, cvld_d;
`endif

  // One S-box column serves both directions: forward uses w3, backward recovers w3 of rk(r-1)
  assign sub_in    = (state_q == ROUND) ? (key_q[31:0] ^ key_q[63:32]) : key_q[31:0];
  assign ks_t      = sub_word({sub_in[23:0], sub_in[31:24]}) ^ {rcon_q, 24'h0};
  assign key_next  = key_fwd(key_q, ks_t);
  assign key_prev  = key_bwd(key_q, ks_t);
  assign round_out = inv_round(data_q, key_prev, cnt_q != 4'd1);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    busy_d  = busy_q;
`ifdef AES_DEC_KEY_CACHE_EN
    ckey_d  = ckey_q;
    crk_d   = crk_q;
    cvld_d  = cvld_q;
`endif
    case (state_q)
      IDLE: if (AES_en) begin
        data_d  = AES_data_in;
        key_d   = AES_key_in;
        rcon_d  = 8'h01;
        cnt_d   = 4'd0;
        busy_d  = 1'b1;
        state_d = KEYX;
`ifdef AES_DEC_KEY_CACHE_EN
        if (cvld_q && (AES_key_in == ckey_q)) begin
          key_d   = crk_q;
          rcon_d  = RCON_LAST;
          state_d = ARK;
        end else begin
          ckey_d = AES_key_in;
          cvld_d = 1'b0;
        end
`endif
      end
      KEYX: begin
        key_d = key_next;
        cnt_d = cnt_q + 4'd1;
        // rcon is left at 0x36 after the last step so ROUND can start walking back from it
        if (cnt_q == 4'd9) begin
          state_d = ARK;
`ifdef AES_DEC_KEY_CACHE_EN
          crk_d  = key_next;
          cvld_d = 1'b1;
`endif
        end else begin
          rcon_d = xtime(rcon_q);
        end
      end
      ARK: begin
        data_d  = data_q ^ key_q;
        cnt_d   = 4'd10;
        state_d = ROUND;
      end
      ROUND: begin
        key_d  = key_prev;
        data_d = round_out;
        rcon_d = rcon_q[0] ? ({1'b0, rcon_q[7:1]} ^ 8'h8d) : {1'b0, rcon_q[7:1]};
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          dout_d  = round_out;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      key_q   <= '0;
      rcon_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
      ckey_q  <= '0;
      crk_q   <= '0;
      cvld_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef AES_DEC_KEY_CACHE_EN
      ckey_q  <= ckey_d;
      crk_q   <= crk_d;
      cvld_q  <= cvld_d;
`endif
    end
  end

  assign AES_data_out       = dout_q;
  assign AES_data_out_valid = valid_q;
  assign AES_busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_top.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_aes_inv_top : directed FIPS-197 and random decryptions of ciphertext from
// a behavioural AES-128 encryptor.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_aes_inv_top;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [127:0] din = '0;
  logic [127:0] kin = '0;
  logic [127:0] dout;
  logic         vld;
  logic         busy;

  aes_inv_top dut (
    .AES_clk           (clk),
    .AES_rst_n         (rst_n),
    .AES_en            (en),
    .AES_data_in       (din),
    .AES_key_in        (kin),
    .AES_data_out      (dout),
    .AES_data_out_valid(vld),
    .AES_busy          (busy)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] sbox [256];
`ifdef AES_DEC_KEY_CACHE_EN
  logic         cvalid = 1'b0;
  logic [127:0] ckey = '0;
`endif

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RT_KEY = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
  localparam logic [127:0] RT_PT  = 128'h000000ab000000000000000000000000;

  logic [127:0] junk [3];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Carry-less product reduced modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gm(a[7:0], b[7:0]) == 8'h01) inv = b[7:0];
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox[a] = s;
    end
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   st [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 16; k++) st[k] = pt[127 - 8*k -: 8] ^ w[k/4][31 - 8*(k%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int k = 0; k < 16; k++) t[k] = sbox[st[4*(((k/4) + (k%4)) % 4) + (k%4)]];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          st[4*c]   = gm(t[4*c], 8'h02) ^ gm(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          st[4*c+1] = t[4*c] ^ gm(t[4*c+1], 8'h02) ^ gm(t[4*c+2], 8'h03) ^ t[4*c+3];
          st[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2], 8'h02) ^ gm(t[4*c+3], 8'h03);
          st[4*c+3] = gm(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3], 8'h02);
        end else begin
          for (int r2 = 0; r2 < 4; r2++) st[4*c+r2] = t[4*c+r2];
        end
      end
      for (int k = 0; k < 16; k++) st[k] = st[k] ^ w[4*r + k/4][31 - 8*(k%4) -: 8];
    end
    for (int k = 0; k < 16; k++) o[127 - 8*k -: 8] = st[k];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int exp_lat(input logic [127:0] key);
`ifdef AES_DEC_KEY_CACHE_EN
    int l;
    l = (cvalid && key == ckey) ? 11 : 21;
    cvalid = 1'b1;
    ckey   = key;
    return l;
`else
    return (key === key) ? 21 : 21;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [127:0] key, input logic [127:0] ct,
                        input logic [127:0] pt);
    int k, bcnt, lat;
    logic [127:0] prev;
    lat  = exp_lat(key);
    prev = dout;
    @(negedge clk);
    en = 1'b1; kin = key; din = ct;
    @(negedge clk);
    en = 1'b0;
    k = 0; bcnt = 0;
    while (vld !== 1'b1 && k < 40) begin
      if (busy === 1'b1) bcnt++;
      if (k == 5) chk({tag, "_held"}, dout, prev);
      @(negedge clk);
      k++;
      if (k >= 1 && k <= 3) din = junk[k-1];
      kin = rnd128();
    end
    chk({tag, "_lat"}, 128'(k), 128'(lat));
    chk({tag, "_busycyc"}, 128'(bcnt), 128'(lat));
    chk({tag, "_data"}, dout, pt);
    chk({tag, "_busyend"}, 128'(busy), 128'd0);
    @(negedge clk);
    chk({tag, "_strobe"}, 128'(vld), 128'd0);
    chk({tag, "_keep"}, dout, pt);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] key_r, pt_r, prev_key;
    int k, p1, p2, l1, l2;
    logic seen;
    junk[0] = 128'ha6f2daeb140fa720529e75d521cbc681;
    junk[1] = 128'hd7b26248e83512275573a1e5e8f263b3;
    junk[2] = 128'hf301a68a9e9ffa50844581d9e290d818;
    build_sbox();

    #1;
    chk("rst_data", dout, '0);
    chk("rst_valid", 128'(vld), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("c1", C1_KEY, C1_CT, C1_PT);
    run_op("c1_again", C1_KEY, C1_CT, C1_PT);
    run_op("appb", B_KEY, B_CT, B_PT);
    run_op("trip", RT_KEY, encrypt(RT_KEY, RT_PT), RT_PT);

    prev_key = '0;
    for (int i = 0; i < 4; i++) begin
      key_r = (i == 2) ? prev_key : rnd128();
      pt_r  = rnd128();
      prev_key = key_r;
      run_op($sformatf("rand%0d", i), key_r, encrypt(key_r, pt_r), pt_r);
    end

    // AES_en held high across two back-to-back operations
    l1 = exp_lat(B_KEY);
    l2 = exp_lat(B_KEY);
    @(negedge clk);
    en = 1'b1; kin = B_KEY; din = B_CT;
    @(negedge clk);
    k = 0; p1 = -1; p2 = -1;
    while (k < 80) begin
      if (vld === 1'b1) begin
        if (p1 < 0) p1 = k;
        else begin
          p2 = k;
          break;
        end
      end
      @(negedge clk);
      k++;
    end
    en = 1'b0;
    chk("held_first", 128'(p1), 128'(l1));
    chk("held_second", 128'(p2), 128'(l1 + 1 + l2));
    chk("held_data", dout, B_PT);
    repeat (2) @(negedge clk);

    // Reset in the middle of an operation
    @(negedge clk);
    en = 1'b1; kin = C1_KEY; din = C1_CT;
    @(negedge clk);
    en = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_data", dout, '0);
    chk("abort_valid", 128'(vld), 128'd0);
    chk("abort_busy", 128'(busy), 128'd0);
`ifdef AES_DEC_KEY_CACHE_EN
    cvalid = 1'b0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (vld === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    chk("abort_quiet", 128'(seen), 128'd0);
    run_op("post_rst", C1_KEY, C1_CT, C1_PT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_inv_top.md
Name: aes_inv_top

Overview:
- Iterative AES-128 inverse cipher. It is the decrypt-side counterpart of the existing AES_top encryptor and uses the same port naming and handshake.
- Accepts a 128-bit ciphertext and the original cipher key, computes one inverse round per clock, and returns the plaintext with a one-cycle valid strobe.
- Computes the final round key internally by forward expansion, then walks the key schedule backwards on the fly. No round-key RAM.

Parameters:
- None. The block is AES-128 only; data and key widths are fixed at 128.

Ports:
- AES_clk  input  1  system clock, rising edge
- AES_rst_n  input  1  reset, asynchronous, active-low
- AES_en  input  1  start request, level-sensitive, sampled only in IDLE
- AES_data_in  input  128  ciphertext, byte 0 at [127:120]
- AES_key_in  input  128  original cipher key (round key 0)
- AES_data_out  output  128  plaintext, registered, held until next completion
- AES_data_out_valid  output  1  one-cycle strobe marking AES_data_out as new
- AES_busy  output  1  high from the start edge until the completion edge

Interface rule (already decided): one clock, AES_clk; reset AES_rst_n is asynchronous and active-low.

Behaviour:
- Reset values: AES_data_out = 0, AES_data_out_valid = 0, AES_busy = 0, FSM = IDLE, all internal state/key/counters = 0. Reset asserted mid-operation aborts immediately with no valid strobe.
- FSM states: IDLE, KEYX, ARK, ROUND.
- IDLE:
  - If AES_en = 1 at edge N: capture AES_data_in and AES_key_in, set rcon = 0x01, set AES_busy = 1, go to KEYX.
- KEYX (edges N+1..N+10):
  - Forward key expansion: key <= expand(key, rcon); rcon <= xtime(rcon).
  - After edge N+10, key = rk10 and rcon = 0x36; go to ARK.
- ARK (edge N+11): state <= data ^ rk10; round counter = 10; go to ROUND.
- ROUND (edges N+12..N+21), for r = 10 down to 1:
  - Compute rk(r-1) combinationally from rk(r) using rcon(r).
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk(r-1)).
  - InvMixColumns is skipped when r = 1.
  - rcon steps backwards: multiply by 0x8D in GF(2^8), i.e. divide by x.
- Completion edge N+21:
  - AES_data_out <= final state; AES_data_out_valid = 1 for exactly one cycle; AES_busy = 0; FSM to IDLE.
- Latency: start sampled at edge N gives valid high after edge N+21 (21 cycles).
- Restart: if AES_en is still high at edge N+22, a new operation starts using the inputs present at N+22. Back-to-back throughput is one result per 22 cycles.
- Input handling: AES_data_in, AES_key_in and AES_en are ignored while AES_busy = 1. Changes during an operation must not affect the result.
- S-boxes:
  - Both forward (key schedule) and inverse (datapath) S-boxes are computed as GF(2^8) inversion (polynomial 0x11B, 0 maps to 0) combined with the forward or inverse affine map. No 256-entry tables.
  - All round logic is combinational between the registers above.
- AES_data_out does not change except on a completion edge or reset.

Optional Feature:
- Macro: AES_DEC_KEY_CACHE_EN.
- With the macro defined:
  - The block keeps a cached copy of the last cipher key and its rk10, plus a cache-valid bit (cleared by reset).
  - On start, if the cache is valid and AES_key_in equals the cached key: skip KEYX, load rk10 from the cache, go straight to ARK.
  - Latency becomes 11 cycles (valid after edge N+11) and AES_busy covers that shorter window.
  - A cache miss takes the normal 21-cycle path and refreshes the cache at the end of KEYX.
- Without the macro: no cache registers; latency is always 21 cycles.

Test Plan:
- FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, AES_data_in 69c4e0d86a7b0430d8cdb78070b4c55a, AES_en pulsed one cycle.
  - Required: AES_data_out = 00112233445566778899aabbccddeeff with valid after exactly 21 cycles; AES_busy high for 21 cycles.
- FIPS-197 App. B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, data 3925841d02dc09fbdc118597196a0b32.
  - Required: output 3243f6a8885a308d313198a2e0370734.
- Round trip with AES_top:
  - Stimulus: key aa2bdb40bff6a5e8caa9ba3ebc1e2acc, plaintext 000000ab000000000000000000000000; feed the encryptor output into this block.
  - Required: decrypted output equals the original plaintext.
- Inputs changing while busy:
  - Stimulus: start C.1, then at cycles 1, 2, 3 drive AES_data_in with a6f2daeb140fa720529e75d521cbc681, d7b26248e83512275573a1e5e8f263b3, f301a68a9e9ffa50844581d9e290d818.
  - Required: output still 00112233445566778899aabbccddeeff.
- Held AES_en and reset abort:
  - Stimulus: hold AES_en high across two operations.
  - Required: valid pulses at cycles 21 and 43.
  - Stimulus: deassert AES_rst_n at cycle 10 of an operation.
  - Required: all outputs return to 0 and no valid pulse appears.
- AES_DEC_KEY_CACHE_EN:
  - Stimulus: run C.1 twice with the same key.
  - Required: first result after 21 cycles, second after 11 cycles, both correct.
  - Stimulus: change the key.
  - Required: latency returns to 21 cycles.
